// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key schedule: expands one 32-bit word per clock into a register file
// and serves a registered 128-bit round key per read for the iterative cipher datapaths.
module aes_key_schedule_seq #(
  parameter int NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [2:0] PH_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_IDX  = 4'(NR);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_key_schedule_seq: NK must be 4, 6 or 8");
    end
  endgenerate

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [5:0]   r_cnt;
  logic [2:0]   r_phase;
  logic [7:0]   r_rcon;
  logic [127:0] r_rk;
  logic [31:0]  r_words [NW];

  logic         w_accept;
  logic [31:0]  w_prev;
  logic [31:0]  w_old;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [31:0]  w_new;
  logic [5:0]   w_base;

  always_comb begin
    w_state_next = r_state;
    key_ready    = 1'b0;
    busy         = 1'b0;
    rk_valid     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        key_ready = 1'b1;
        rk_valid  = (r_state == S_DONE);
        if (key_valid) w_state_next = S_EXPAND;
      end
      S_EXPAND: begin
        busy = 1'b1;
        if (r_cnt == LAST_W) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = key_ready && key_valid;

  // r_phase tracks i mod NK so no divider is needed for the NK=6 case.
  assign w_prev   = r_words[r_cnt - 6'd1];
  assign w_old    = r_words[r_cnt - NK_W];
  assign w_sub_in = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign w_sub[8*gi +: 8] = SBOX[w_sub_in[8*gi +: 8]];
    end
  endgenerate

  always_comb begin
    w_temp = w_prev;
    if (r_phase == 3'd0)
      w_temp = w_sub ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_phase == 3'd4)
      w_temp = w_sub;
  end

  assign w_new  = w_old ^ w_temp;
  assign w_base = {rk_idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_phase <= '0;
      r_rcon  <= 8'h01;
      r_rk    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt   <= NK_W;
        r_phase <= '0;
        r_rcon  <= 8'h01;
      end else if (busy) begin
        r_cnt   <= r_cnt + 6'd1;
        r_phase <= (r_phase == PH_LAST) ? 3'd0 : r_phase + 3'd1;
        if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
      end
      // Pre-edge rk_valid gates the read, so a read on the final-write edge returns 0.
      if (rk_valid && rk_idx <= NR_IDX)
        r_rk <= {r_words[w_base], r_words[w_base + 6'd1],
                 r_words[w_base + 6'd2], r_words[w_base + 6'd3]};
      else
        r_rk <= '0;
    end
  end

  // Contents are left uncleared by reset; rk_valid masks stale words.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NK; k++) r_words[k] <= key[255 - 32*k -: 32];
    end else if (busy) begin
      r_words[r_cnt] <= w_new;
    end
  end

  assign rk = r_rk;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench: three key-schedule instances (NK=8,4,6) against a GF(2^8)-derived
// behavioural model, plus FIPS-197 literal vectors.
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              key_valid;
  logic [255:0]      key;
  logic [3:0]        rk_idx;
  logic [2:0]        kr, bz, rv;
  logic [2:0][127:0] rkp;

  aes_key_schedule_seq #(.NK(8)) u_nk8 (.clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(kr[0]),
    .key(key), .busy(bz[0]), .rk_valid(rv[0]), .rk_idx(rk_idx), .rk(rkp[0]));
  aes_key_schedule_seq #(.NK(4)) u_nk4 (.clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(kr[1]),
    .key(key), .busy(bz[1]), .rk_valid(rv[1]), .rk_idx(rk_idx), .rk(rkp[1]));
  aes_key_schedule_seq #(.NK(6)) u_nk6 (.clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(kr[2]),
    .key(key), .busy(bz[2]), .rk_valid(rv[2]), .rk_idx(rk_idx), .rk(rkp[2]));

  typedef logic [59:0][31:0] sched_t;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];
  int           m_nk [3] = '{8, 4, 6};
  int           m_rem [3];
  bit           m_have [3];
  sched_t       m_sched [3];
  logic [127:0] m_rk [3];
  bit           model_on = 1'b0;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15 - n -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic sched_t expand(input logic [255:0] k, input int nk);
    sched_t w = '0;
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gf_mul(rc, 8'h02);
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  function automatic logic [127:0] rk_of(input sched_t w, input int idx);
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference model: schedule computed whole at acceptance, timing as a countdown.
  initial begin
    logic [127:0] nrk;
    wait (model_on);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          m_rem[d] = 0; m_have[d] = 1'b0; m_rk[d] = '0;
        end else begin
          nrk = (m_have[d] && int'(rk_idx) <= m_nk[d] + 6) ? rk_of(m_sched[d], int'(rk_idx)) : 128'h0;
          if (m_rem[d] == 0 && key_valid) begin
            m_sched[d] = expand(key, m_nk[d]);
            m_rem[d]   = 4 * (m_nk[d] + 7) - m_nk[d];
            m_have[d]  = 1'b0;
          end else if (m_rem[d] > 0) begin
            m_rem[d]--;
            if (m_rem[d] == 0) m_have[d] = 1'b1;
          end
          m_rk[d] = nrk;
        end
      end
    end
  end

  initial begin
    wait (model_on);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("key_ready nk%0d", m_nk[d]), 128'(kr[d]), 128'(m_rem[d] == 0));
        chk($sformatf("busy nk%0d", m_nk[d]), 128'(bz[d]), 128'(m_rem[d] != 0));
        chk($sformatf("rk_valid nk%0d", m_nk[d]), 128'(rv[d]), 128'(m_have[d]));
        chk($sformatf("rk nk%0d", m_nk[d]), rkp[d], m_rk[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [255:0] k);
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic measure(input string tag);
    int first [3] = '{-1, -1, -1};
    chk({tag, " rk_valid drop"}, 128'(rv), 128'(0));
    for (int c = 1; c <= 100; c++) begin
      tick();
      for (int d = 0; d < 3; d++) if (first[d] < 0 && rv[d]) first[d] = c;
      if (first[0] >= 0 && first[1] >= 0 && first[2] >= 0) break;
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s latency nk%0d", tag, m_nk[d]), 128'(first[d]), 128'(4 * (m_nk[d] + 7) - m_nk[d]));
  endtask

  task automatic rd(input int idx);
    rk_idx = 4'(idx);
    tick();
  endtask

  initial begin
    sched_t s;
    logic [255:0] kb;
    logic [7:0] inv;
    int first;
    rst_n = 1'b0; key_valid = 1'b0; key = '0; rk_idx = '0;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gf_mul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int d = 0; d < 3; d++) begin m_rem[d] = 0; m_have[d] = 1'b0; m_rk[d] = '0; end
    model_on = 1'b1;

    chk("model sbox 00", 128'(sb[0]), 128'h63);
    chk("model sbox 53", 128'(sb[8'h53]), 128'hed);
    s = expand(K1, 8);
    chk("model K1 rk2", rk_of(s, 2), 128'ha573c29fa176c498a97fce93a572c09c);
    chk("model K1 rk14", rk_of(s, 14), 128'h24fc79ccbf0979e9371ac23c6d68de36);
    s = expand(K2, 8);
    chk("model K2 w8", 128'(s[8]), 128'h9ba35411);
    chk("model K2 w59", 128'(s[59]), 128'h706c631e);

    repeat (2) @(posedge clk);
    #1;
    chk("reset key_ready", 128'(kr), 128'h7);
    chk("reset busy", 128'(bz), 128'h0);
    chk("reset rk_valid", 128'(rv), 128'h0);
    chk("reset rk", rkp[0], 128'h0);
    rst_n = 1'b1;
    tick();

    load(K1);
    measure("t1");
    rd(0);  chk("t1 rk0", rkp[0], 128'h000102030405060708090a0b0c0d0e0f);
    rd(1);  chk("t1 rk1", rkp[0], 128'h101112131415161718191a1b1c1d1e1f);
    rd(2);  chk("t1 rk2", rkp[0], 128'ha573c29fa176c498a97fce93a572c09c);
    rd(14); chk("t1 rk14", rkp[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd(15); chk("t1 rk15", rkp[0], 128'h0);

    kb = rand256();
    load(K2);
    chk("t4 rk_valid drop", 128'(rv[0]), 128'h0);
    repeat (9) tick();
    key = kb;
    key_valid = 1'b1;
    chk("t4 key_ready busy", 128'(kr), 128'h0);
    tick();
    key_valid = 1'b0;
    first = -1;
    for (int c = 11; c <= 100; c++) begin
      tick();
      if (rv[0]) begin first = c; break; end
    end
    chk("t2 latency", 128'(first), 128'd52);
    rd(14); chk("t2 w59", 128'(rkp[0][31:0]), 128'h706c631e);
    rd(2);  chk("t2 w8", 128'(rkp[0][127:96]), 128'h9ba35411);
    rd(0);  chk("t4 kept A", rkp[0], K2[255:128]);
    load(kb);
    measure("t4");
    rd(0);  chk("t4 B rk0", rkp[0], kb[255:128]);
    rd(1);  chk("t4 B rk1", rkp[0], kb[127:0]);

    load({128'h2b7e151628aed2a6abf7158809cf4f3c, kb[127:0]});
    measure("t3");
    rd(10); chk("t3 rk10", rkp[1], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 11; i <= 15; i++) begin
      rd(i); chk($sformatf("t3 rk%0d", i), rkp[1], 128'h0);
    end

    rk_idx = 4'd0;
    load(K1);
    repeat (20) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t5 key_ready", 128'(kr), 128'h7);
    chk("t5 busy", 128'(bz), 128'h0);
    chk("t5 rk_valid", 128'(rv), 128'h0);
    chk("t5 rk", rkp[0], 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    load(K1);
    measure("t5");
    rd(2); chk("t5 rk2", rkp[0], 128'ha573c29fa176c498a97fce93a572c09c);

    s = expand(K1, 8);
    for (int i = 14; i >= 0; i--) begin
      rd(i); chk($sformatf("t6 stream rk%0d", i), rkp[0], rk_of(s, i));
    end

    for (int it = 0; it < 6; it++) begin
      repeat (90) begin
        key_valid = ($urandom_range(0, 15) == 0);
        if (key_valid) key = rand256();
        rk_idx = 4'($urandom_range(0, 15));
        tick();
      end
      key_valid = 1'b0;
    end
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
